// File: rtl/queue_sensor_conditioner.sv
// Debounces the entry and front photocells into one-cycle active-low strobes for the queue.
// Optional stuck-beam detection is built when QUEUE_SENSOR_STUCK_DETECT_EN is defined.
module queue_sensor_conditioner #(
    parameter int unsigned DB_CYCLES    = 4,
    parameter int unsigned DB_W         = 3,
    parameter int unsigned STUCK_CYCLES = 1024,
    parameter int unsigned STUCK_W      = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Signal_end_raw,
    input  logic       Signal_front_raw,
    output logic       Signal_end,
    output logic       Signal_front,
    output logic [7:0] glitch_cnt,
    output logic       stuck_fault
);

    localparam int unsigned CH = 2;
    localparam int unsigned GW = 8;

    typedef enum logic [1:0] {
        ST_HIGH,
        ST_FALL_CHK,
        ST_LOW,
        ST_RISE_CHK
    } state_e;

    // Reject parameter sets the counters cannot represent
    if (DB_CYCLES < 2 || DB_CYCLES > (2 ** DB_W) - 1) begin : g_bad_db
        $error("DB_CYCLES out of range for DB_W");
    end
    if (STUCK_CYCLES > (2 ** STUCK_W) - 1) begin : g_bad_stuck
        $error("STUCK_CYCLES does not fit in STUCK_W");
    end

    // Channel index 0 = entry, 1 = front
    logic [CH-1:0] raw;
    logic [CH-1:0] meta_q;
    logic [CH-1:0] sync_q;

    assign raw = {Signal_front_raw, Signal_end_raw};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    state_e          state_q [CH];
    state_e          state_d [CH];
    logic [DB_W-1:0] cnt_q   [CH];
    logic [DB_W-1:0] cnt_d   [CH];
    logic [CH-1:0]   strobe_n_q;
    logic [CH-1:0]   strobe_n_d;
    logic [CH-1:0]   abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < CH; c++) begin
                state_q[c] <= ST_HIGH;
                cnt_q[c]   <= '0;
            end
            strobe_n_q <= '1;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            strobe_n_q <= strobe_n_d;
        end
    end

    // Per-channel debounce: a change is accepted only after DB_CYCLES matching samples
    always_comb begin
        strobe_n_d = '1;
        abort      = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            case (state_q[c])
                ST_HIGH: begin
                    if (!sync_q[c]) begin
                        state_d[c] = ST_FALL_CHK;
                        cnt_d[c]   = DB_W'(1);
                    end
                end
                ST_FALL_CHK: begin
                    if (sync_q[c]) begin
                        state_d[c] = ST_HIGH;
                        cnt_d[c]   = '0;
                        abort[c]   = 1'b1;
                    end else if (cnt_q[c] == DB_W'(DB_CYCLES - 1)) begin
                        state_d[c]    = ST_LOW;
                        cnt_d[c]      = '0;
                        strobe_n_d[c] = 1'b0;
                    end else begin
                        cnt_d[c] = cnt_q[c] + DB_W'(1);
                    end
                end
                ST_LOW: begin
                    if (sync_q[c]) begin
                        state_d[c] = ST_RISE_CHK;
                        cnt_d[c]   = DB_W'(1);
                    end
                end
                ST_RISE_CHK: begin
                    if (!sync_q[c]) begin
                        state_d[c] = ST_LOW;
                        cnt_d[c]   = '0;
                    end else if (cnt_q[c] == DB_W'(DB_CYCLES - 1)) begin
                        state_d[c] = ST_HIGH;
                        cnt_d[c]   = '0;
                    end else begin
                        cnt_d[c] = cnt_q[c] + DB_W'(1);
                    end
                end
                default: begin
                    state_d[c] = ST_HIGH;
                    cnt_d[c]   = '0;
                end
            endcase
        end
    end

    assign Signal_end   = strobe_n_q[0];
    assign Signal_front = strobe_n_q[1];

    // Saturating glitch counter; both channels may abort in the same cycle
    logic [1:0]  glitch_inc;
    logic [GW:0] glitch_sum;
    logic [GW-1:0] glitch_d;

    always_comb begin
        glitch_inc = 2'(abort[0]) + 2'(abort[1]);
        glitch_sum = (GW+1)'(glitch_cnt) + (GW+1)'(glitch_inc);
        glitch_d   = glitch_sum[GW] ? '1 : glitch_sum[GW-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt <= '0;
        end else begin
            glitch_cnt <= glitch_d;
        end
    end

`ifdef QUEUE_SENSOR_STUCK_DETECT_EN
    logic [STUCK_W-1:0] stuck_q [CH];
    logic [STUCK_W-1:0] stuck_d [CH];
    logic               stuck_hit;

    // Timers run only while a beam is held broken and saturate at all-ones
    always_comb begin
        stuck_hit = 1'b0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (state_q[c] == ST_LOW) begin
                stuck_d[c] = (stuck_q[c] == '1) ? stuck_q[c] : stuck_q[c] + STUCK_W'(1);
            end else begin
                stuck_d[c] = '0;
            end
            if (stuck_d[c] >= STUCK_W'(STUCK_CYCLES)) begin
                stuck_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < CH; c++) begin
                stuck_q[c] <= '0;
            end
            stuck_fault <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                stuck_q[c] <= stuck_d[c];
            end
            stuck_fault <= stuck_fault | stuck_hit;
        end
    end
`else
    assign stuck_fault = 1'b0;
`endif

endmodule

// File: tb/tb_queue_sensor_conditioner.sv
// Directed bench for queue_sensor_conditioner with DB_CYCLES=4 and STUCK_CYCLES=16.
module tb_queue_sensor_conditioner;

    logic       clk;
    logic       reset_n;
    logic       Signal_end_raw;
    logic       Signal_front_raw;
    logic       Signal_end;
    logic       Signal_front;
    logic [7:0] glitch_cnt;
    logic       stuck_fault;

    int checks;
    int passed;
    int cyc;
    int n_end;
    int n_front;
    int first_end;
    int first_front;
    int exp_stuck;

    queue_sensor_conditioner #(
        .DB_CYCLES   (4),
        .DB_W        (3),
        .STUCK_CYCLES(16),
        .STUCK_W     (11)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .Signal_end_raw  (Signal_end_raw),
        .Signal_front_raw(Signal_front_raw),
        .Signal_end      (Signal_end),
        .Signal_front    (Signal_front),
        .glitch_cnt      (glitch_cnt),
        .stuck_fault     (stuck_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic obs_clear();
        cyc         = 0;
        n_end       = 0;
        n_front     = 0;
        first_end   = -1;
        first_front = -1;
    endtask

    // Cycle index 1 is the first edge that samples the inputs just driven
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (Signal_end === 1'b0) begin
                n_end++;
                if (first_end < 0) first_end = cyc;
            end
            if (Signal_front === 1'b0) begin
                n_front++;
                if (first_front < 0) first_front = cyc;
            end
        end
    endtask

    task automatic front_glitch();
        Signal_front_raw = 1'b0;
        run(2);
        Signal_front_raw = 1'b1;
        run(4);
    endtask

    initial begin
        checks           = 0;
        passed           = 0;
        reset_n          = 1'b0;
        Signal_end_raw   = 1'b1;
        Signal_front_raw = 1'b1;
        obs_clear();
        run(3);
        check("reset_end", int'(Signal_end), 1);
        check("reset_front", int'(Signal_front), 1);
        check("reset_glitch", int'(glitch_cnt), 0);
        check("reset_stuck", int'(stuck_fault), 0);

        // Reset while the entry channel sits in FALL_CHK
        reset_n = 1'b1;
        obs_clear();
        Signal_end_raw = 1'b0;
        run(3);
        reset_n = 1'b0;
        Signal_end_raw = 1'b1;
        run(2);
        reset_n = 1'b1;
        run(10);
        check("midreset_no_strobe", n_end, 0);
        check("midreset_glitch", int'(glitch_cnt), 0);

        // Clean entry event
        obs_clear();
        Signal_end_raw = 1'b0;
        run(10);
        Signal_end_raw = 1'b1;
        run(10);
        check("entry_strobes", n_end, 1);
        check("entry_latency", first_end, 6);
        check("entry_front_quiet", n_front, 0);
        check("entry_glitch", int'(glitch_cnt), 0);

        // Short front pulse is rejected
        obs_clear();
        front_glitch();
        check("glitch_no_strobe", n_front, 0);
        check("glitch_one", int'(glitch_cnt), 1);

        // Entry bounce while held broken
        obs_clear();
        Signal_end_raw = 1'b0;
        run(6);
        Signal_end_raw = 1'b1;
        run(1);
        Signal_end_raw = 1'b0;
        run(6);
        Signal_end_raw = 1'b1;
        run(8);
        check("bounce_strobes", n_end, 1);
        check("bounce_latency", first_end, 6);
        check("bounce_glitch", int'(glitch_cnt), 1);

        // Both channels fall together
        obs_clear();
        Signal_end_raw   = 1'b0;
        Signal_front_raw = 1'b0;
        run(6);
        Signal_end_raw   = 1'b1;
        Signal_front_raw = 1'b1;
        run(8);
        check("simul_end_count", n_end, 1);
        check("simul_front_count", n_front, 1);
        check("simul_end_cycle", first_end, 6);
        check("simul_front_cycle", first_front, 6);

        // Double abort in one cycle adds two
        obs_clear();
        Signal_end_raw   = 1'b0;
        Signal_front_raw = 1'b0;
        run(2);
        Signal_end_raw   = 1'b1;
        Signal_front_raw = 1'b1;
        run(4);
        check("double_abort", int'(glitch_cnt), 3);
        check("double_abort_quiet", n_end + n_front, 0);

        // Saturation edge: 254 then a double abort
        for (int i = 0; i < 251; i++) front_glitch();
        check("glitch_254", int'(glitch_cnt), 254);
        Signal_end_raw   = 1'b0;
        Signal_front_raw = 1'b0;
        run(2);
        Signal_end_raw   = 1'b1;
        Signal_front_raw = 1'b1;
        run(4);
        check("glitch_sat_double", int'(glitch_cnt), 255);
        for (int i = 0; i < 50; i++) front_glitch();
        check("glitch_sat_hold", int'(glitch_cnt), 255);
        check("stuck_before", int'(stuck_fault), 0);

        // Front beam held broken well past STUCK_CYCLES
`ifdef QUEUE_SENSOR_STUCK_DETECT_EN
        exp_stuck = 1;
`else
        exp_stuck = 0;
`endif
        obs_clear();
        Signal_front_raw = 1'b0;
        run(30);
        check("stuck_set", int'(stuck_fault), exp_stuck);
        Signal_front_raw = 1'b1;
        run(10);
        check("stuck_sticky", int'(stuck_fault), exp_stuck);
        check("stuck_one_strobe", n_front, 1);

        // Reset clears statistics
        reset_n = 1'b0;
        run(2);
        check("final_glitch", int'(glitch_cnt), 0);
        check("final_stuck", int'(stuck_fault), 0);
        reset_n = 1'b1;
        run(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
